// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared constants and types for the LED hex scanner.
//   SEG_BLANK      - segment pattern with every segment off (active-low).
//   SEG_ALL_OFF_AN - digit-enable word with every digit off (active-low).
//   HEX_SEG_TABLE  - 16-entry hex-to-segment table, bit order {g,f,e,d,c,b,a},
//                    active-low.
//   digit_idx_t    - 3-bit digit index (0 = rightmost digit).
package led_scan_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam logic [7:0] SEG_ALL_OFF_AN = 8'hFF;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/hex7seg.sv
// hex7seg: purely combinational nibble to seven-segment decoder.
//   nibble - 4-bit hex value to show
//   seg    - active-low segment drive, bit order {g,f,e,d,c,b,a}
module hex7seg
    import led_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/led_hex_scanner.sv
// led_hex_scanner: shows a 32-bit word as eight hex digits on a
// time-multiplexed common-anode seven-segment display.
//
// A free-running divider keeps each digit enabled for CLK_DIV cycles. The
// displayed word and decimal-point mask are snapshotted only at the end of a
// full scan frame, so a digit never changes part way through a frame.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   value      - word to display, nibble i drives digit i (digit 0 rightmost)
//   dp_mask    - bit i lights the decimal point of digit i
//   an         - digit enables, active-low
//   seg        - segment drives, active-low, {g,f,e,d,c,b,a}
//   dp         - decimal-point drive, active-low
//   frame_tick - one-cycle pulse on the edge that loads the snapshot
//
// Build option: define LED_SCAN_LZB_EN to blank leading zero digits
// (digit 0 is never blanked, decimal points are unaffected).
module led_hex_scanner
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam digit_idx_t        IDX_LAST = digit_idx_t'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [31:0]      shadow_val_q, shadow_val_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    logic             digit_wrap;
    logic             frame_end;
    logic [3:0]       nibble_sel;
    logic [6:0]       hex_seg;
    logic             lead_blank;

    // Divider, digit index and snapshot next-state.
    always_comb begin
        digit_wrap   = (cnt_q == CNT_LAST);
        frame_end    = digit_wrap && (idx_q == IDX_LAST);

        cnt_d        = digit_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d        = digit_wrap ? idx_q + digit_idx_t'(1) : idx_q;
        shadow_val_d = frame_end ? value   : shadow_val_q;
        shadow_dp_d  = frame_end ? dp_mask : shadow_dp_q;
    end

    // Outputs are computed from the next-state index and snapshot so that the
    // registered drives line up with the digit that becomes active at the edge.
    assign nibble_sel = shadow_val_d[{idx_d, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble_sel),
        .seg    (hex_seg)
    );

`ifdef LED_SCAN_LZB_EN
    // A digit is a leading zero when it and every more-significant nibble
    // are zero; shifting the word down by the digit position tests exactly that.
    assign lead_blank = (idx_d != digit_idx_t'(0)) &&
                        ((shadow_val_d >> {idx_d, 2'b00}) == 32'd0);
`else
    assign lead_blank = 1'b0;
`endif

    always_comb begin
        an_d         = ~(8'(1) << idx_d);
        seg_d        = lead_blank ? SEG_BLANK : hex_seg;
        dp_d         = ~shadow_dp_d[idx_d];
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            an_q         <= SEG_ALL_OFF_AN;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
